// File: rtl/nibble_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sub_seq
// Function : W-bit start/done subtracter built on a 4-bit combinational
//            subtract slice, one nibble per clock, borrow carried in br_r.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_sub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   borrow_out,
  output logic [3:0]             sub_a,
  output logic [3:0]             sub_b,
  output logic                   sub_cin,
  input  logic [3:0]             sub_diff,
  input  logic                   sub_borrow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] C_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            br_r;

  logic [3:0]      w_a_nib [NIBBLES];
  logic [3:0]      w_b_nib [NIBBLES];

  // Nibble views of the latched operands, selected by r_idx during RUN.
  for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
    assign w_a_nib[g] = a_r[4*g +: 4];
    assign w_b_nib[g] = b_r[4*g +: 4];
  end

  always_comb begin
    sub_a   = 4'd0;
    sub_b   = 4'd0;
    sub_cin = 1'b0;
    if (r_state == RUN) begin
      sub_a   = w_a_nib[r_idx];
      sub_b   = w_b_nib[r_idx];
      sub_cin = br_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      a_r        <= '0;
      b_r        <= '0;
      br_r       <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            a_r     <= op_a;
            b_r     <= op_b;
            br_r    <= bin;
            r_idx   <= '0;
            r_state <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) begin
              result[4*n +: 4] <= sub_diff;
            end
          end
          br_r <= sub_borrow;
          if (r_idx == C_LAST) begin
            borrow_out <= sub_borrow;
            r_state    <= DONE;
            done       <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_sub_seq
// Function : Directed self-checking bench for nibble_sub_seq (NIBBLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_sub_seq;

  localparam int C_NIB = 4;
  localparam int C_W   = 4 * C_NIB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [C_W-1:0]   op_a = '0;
  logic [C_W-1:0]   op_b = '0;
  logic             bin = 1'b0;
  logic             busy;
  logic             done;
  logic [C_W-1:0]   result;
  logic             borrow_out;
  logic [3:0]       sub_a;
  logic [3:0]       sub_b;
  logic             sub_cin;
  logic [3:0]       w_diff;
  logic             w_borrow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the 4-bit ripple subtract slice.
  assign {w_borrow, w_diff} = {1'b0, sub_a} - {1'b0, sub_b} - {4'd0, sub_cin};

  nibble_sub_seq #(.NIBBLES(C_NIB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .borrow_out (borrow_out),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_cin    (sub_cin),
    .sub_diff   (w_diff),
    .sub_borrow (w_borrow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands at a falling edge and returns just after the accept edge,
  // scrambling the inputs so only the latched copies can be used.
  task automatic accept(input logic [C_W-1:0] a, input logic [C_W-1:0] b, input logic bi);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 16'hA5C3;
    op_b  = 16'h5A3C;
    bin   = ~bi;
  endtask

  // Counts falling edges until done is seen; lat = 0 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [C_W-1:0] a, input logic [C_W-1:0] b,
                        input logic bi, input logic [C_W-1:0] exp_res, input logic exp_bo);
    int lat;
    accept(a, b, bi);
    wait_done(lat);
    check({tag, "_latency"}, lat, C_NIB + 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_borrow"}, borrow_out, exp_bo);
    check({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat;
    logic [C_W-1:0] ra, rb;
    logic           rbi;
    logic [C_W:0]   ref_full;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_sub_a", sub_a, 0);
    rst_n = 1'b1;

    run_op("basic",   16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0);
    run_op("ripple",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    run_op("bin_msb", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0);
    run_op("eq_bin",  16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1);
    run_op("eq_zero", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    run_op("mixed",   16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0);
    run_op("mid_rip", 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0);

    // start raised during RUN and during DONE must be ignored
    accept(16'h1234, 16'h0034, 1'b0);
    @(negedge clk);
    op_a  = 16'hFFFF;
    op_b  = 16'h0001;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_latency", lat, 3);
    check("ign_result", result, 16'h1200);
    start = 1'b1;
    @(negedge clk);
    check("ign_no_redone", done, 0);
    check("ign_idle", busy, 0);
    check("ign_hold", result, 16'h1200);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("next_latency", lat, C_NIB + 1);
    check("next_result", result, 16'hFFFE);
    check("next_borrow", borrow_out, 0);
    @(negedge clk);

    // asynchronous reset in the second RUN cycle
    accept(16'h1234, 16'h0034, 1'b0);
    @(posedge clk);
    #1;
    check("mid_sub_a", sub_a, 4'h3);
    check("mid_sub_b", sub_b, 4'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_result", result, 0);
    check("ar_borrow", borrow_out, 0);
    check("ar_sub_a", sub_a, 0);
    check("ar_sub_b", sub_b, 0);
    check("ar_sub_cin", sub_cin, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1);

    // reference-model spot checks
    for (int i = 0; i < 20; i++) begin
      ra  = C_W'($urandom);
      rb  = C_W'($urandom);
      rbi = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} - {1'b0, rb} - {{C_W{1'b0}}, rbi};
      run_op("rand", ra, rb, rbi, ref_full[C_W-1:0], ref_full[C_W]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
